// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: req0 (ALU/EX) and req1 (IO/load). Grants are round-robin.
//   Also holds a per-register scoreboard of pending writes. The issue stage
//   reserves a destination, and the reservation clears when that write
//   reaches the register file.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   rsv_valid, rsv_addr     reserve a destination register (issue stage)
//   chk_addr0/1             operand registers to test
//   chk_busy0/1             operand has a pending write (combinational)
//   reqN_valid/addr/data    writeback request N (N = 0 EX, 1 IO/load)
//   reqN_ready              request N accepted this cycle (combinational)
//   rf_we/rf_waddr/rf_din   registered register-file write port
//   err_waw                 1-cycle pulse: a reservation hit an already-busy register
//
// Handshake: a request transfers on a cycle where reqN_valid && reqN_ready.
//   ready depends on both valids and the round-robin pointer. A requester
//   that is not granted must hold valid/addr/data stable until it is granted.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr0,
  input  logic [ADDR_W-1:0] chk_addr1,
  output logic              chk_busy0,
  output logic              chk_busy1,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_din,
  output logic              err_waw
);

  localparam int NREG = 1 << ADDR_W;

  // rr_ptr = 0 means req0 wins the next contested cycle.
  logic              rr_ptr;
  logic [NREG-1:0]   busy;

  logic              grant0;
  logic              grant1;
  logic              contested;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_commit;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic              waw_hit;

  always_comb begin
    contested = req0_valid & req1_valid;
    grant0    = req0_valid & (~req1_valid | ~rr_ptr);
    grant1    = req1_valid & (~req0_valid |  rr_ptr);
    win_valid = grant0 | grant1;
    win_addr  = grant1 ? req1_addr : req0_addr;
    win_data  = grant1 ? req1_data : req0_data;
    // Register 0 is hardwired: the write is accepted but never reaches the file.
    win_commit = win_valid && (win_addr != '0);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The register file forwards din to a same-cycle read, so a register that
  // is committing right now no longer counts as busy for the reader.
  assign chk_busy0 = busy[chk_addr0] & ~(rf_we && (rf_waddr == chk_addr0));
  assign chk_busy1 = busy[chk_addr1] & ~(rf_we && (rf_waddr == chk_addr1));

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    // Bit 0 is never set, so busy[0] stays at its reset value of 0.
    if (rsv_valid && (rsv_addr != '0)) set_vec[rsv_addr] = 1'b1;
    if (rf_we) clr_vec[rf_waddr] = 1'b1;
    // A reservation on a register whose write is committing this cycle is a
    // clean handover, not a write-after-write hazard.
    waw_hit = rsv_valid && (rsv_addr != '0) && busy[rsv_addr]
              && !(rf_we && (rf_waddr == rsv_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      busy     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_din   <= '0;
      err_waw  <= 1'b0;
    end else begin
      if (contested) rr_ptr <= ~rr_ptr;
      rf_we <= win_commit;
      // Address and data hold their last committed values when idle.
      if (win_commit) begin
        rf_waddr <= win_addr;
        rf_din   <= win_data;
      end
      // OR-ing set_vec in after the clear lets a new reservation win over a
      // commit to the same register at the same edge.
      busy    <= (busy & ~clr_vec) | set_vec;
      err_waw <= waw_hit;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: reset check, a table of per-cycle vectors
// with hand-derived grants/busy/err, a write scoreboard for the registered
// register-file port, and a hand-written mid-operation reset sequence.
module tb_rf_writeback_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] chk_addr0;
  logic [ADDR_W-1:0] chk_addr1;
  logic              chk_busy0;
  logic              chk_busy1;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_din;
  logic              err_waw;

  rf_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din), .err_waw(err_waw)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic              rv;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] c0;
    logic [ADDR_W-1:0] c1;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              g0;   // expected req0_ready
    logic              g1;   // expected req1_ready
    logic              b0;   // expected chk_busy0
    logic              b1;   // expected chk_busy1
    logic              err;  // expected err_waw after this cycle's edge
  } vec_t;

  vec_t tbl[$];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  function automatic vec_t mk(
    input logic rv, input logic [ADDR_W-1:0] ra,
    input logic [ADDR_W-1:0] c0, input logic [ADDR_W-1:0] c1,
    input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
    input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
    input logic g0, input logic g1, input logic b0, input logic b1,
    input logic err);
    vec_t v;
    v.rv = rv; v.ra = ra; v.c0 = c0; v.c1 = c1;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.b0 = b0; v.b1 = b1; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    rsv_valid  = v.rv; rsv_addr  = v.ra;
    chk_addr0  = v.c0; chk_addr1 = v.c1;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then check the
  // registered write port and err_waw just after the edge.
  task automatic run_vec(input vec_t v, input string name);
    logic [ADDR_W+DATA_W-1:0] e;
    drive(v);
    @(negedge clk);
    check({name, ".ready0"}, 64'(req0_ready), 64'(v.g0));
    check({name, ".ready1"}, 64'(req1_ready), 64'(v.g1));
    check({name, ".busy0"},  64'(chk_busy0),  64'(v.b0));
    check({name, ".busy1"},  64'(chk_busy1),  64'(v.b1));
    if (v.g0 && v.a0 != '0) exp_q.push_back({v.a0, v.d0});
    if (v.g1 && v.a1 != '0) exp_q.push_back({v.a1, v.d1});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, ".rf_we"},    64'(rf_we),    64'd1);
      check({name, ".rf_waddr"}, 64'(rf_waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
      check({name, ".rf_din"},   64'(rf_din),   64'(e[DATA_W-1:0]));
      last_addr = e[ADDR_W+DATA_W-1:DATA_W];
      last_din  = e[DATA_W-1:0];
    end else begin
      check({name, ".rf_we"},         64'(rf_we),    64'd0);
      check({name, ".rf_waddr_hold"}, 64'(rf_waddr), 64'(last_addr));
      check({name, ".rf_din_hold"},   64'(rf_din),   64'(last_din));
    end
    check({name, ".err_waw"}, 64'(err_waw), 64'(v.err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with a request pending.
    drive(idle);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hCAFE_0001;
    repeat (2) @(posedge clk);
    #1;
    check("reset.rf_we",    64'(rf_we),    64'd0);
    check("reset.err_waw",  64'(err_waw),  64'd0);
    check("reset.rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset.rf_din",   64'(rf_din),   64'd0);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      chk_addr0 = ADDR_W'(i);
      chk_addr1 = ADDR_W'((1 << ADDR_W) - 1 - i);
      #1;
      check($sformatf("reset.busy0[%0d]", i), 64'(chk_busy0), 64'd0);
      check($sformatf("reset.busy1[%0d]", i), 64'(chk_busy1), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(idle);
    last_addr = '0;
    last_din  = '0;

    //           rv ra c0 c1  v0 a0 d0            v1 a1 d1       g0 g1 b0 b1 err
    // Single write through reservation.
    tbl.push_back(mk(1, 5, 5, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0,  1, 5, 32'hDEADBEEF,  0, 0, 0,         1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    // Contention, losers hold their request.
    tbl.push_back(mk(0, 0, 1, 2,  1, 1, 32'h11,        1, 2, 32'h22,    1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  1, 1, 32'h33,        1, 2, 32'h22,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  1, 1, 32'h33,        1, 2, 32'h44,    1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2,  1, 1, 32'h55,        1, 2, 32'h44,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 1, 32'h55,        0, 0, 0,         1, 0, 0, 0, 0));
    // Uncontested grants leave the pointer alone.
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             1, 4, 32'h44,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 6, 32'h66,        1, 8, 32'h88,    1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             1, 8, 32'h88,    0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 10, 32'hA0,       1, 12, 32'hC0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, 10, 32'hA0,       0, 0, 0,         1, 0, 0, 0, 0));
    // Register 0.
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             1, 0, 32'h1234,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    // Set/clear collision on 7, WAW on 9.
    tbl.push_back(mk(1, 7, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 7, 0,  0, 0, 0,             0, 0, 0,         0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 7, 9,  1, 7, 32'h77,        0, 0, 0,         1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 7, 7, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 7, 9,  0, 0, 0,             0, 0, 0,         0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 9,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 7, 9,  1, 7, 32'h78,        1, 9, 32'h99,    1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 7, 9,  0, 0, 0,             1, 9, 32'h99,    0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 7, 9,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 3, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Mid-operation reset: reg 3 busy, a write to 3 accepted in the reset cycle.
    drive(mk(1, 3, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    check("midrst.rf_we",    64'(rf_we),    64'd0);
    check("midrst.err_waw",  64'(err_waw),  64'd0);
    check("midrst.rf_waddr", 64'(rf_waddr), 64'd0);
    check("midrst.rf_din",   64'(rf_din),   64'd0);
    rst_n = 1'b1;
    drive(idle);
    chk_addr0 = 5'd3;
    #1;
    check("midrst.busy3", 64'(chk_busy0), 64'd0);
    exp_q.delete();
    last_addr = '0;
    last_din  = '0;
    run_vec(mk(0, 0, 3, 0, 1, 1, 32'h111, 1, 2, 32'h222, 1, 0, 0, 0, 0), "post_rst0");
    run_vec(mk(0, 0, 3, 0, 0, 0, 0,       1, 2, 32'h222, 0, 1, 0, 0, 0), "post_rst1");
    run_vec(idle, "post_rst2");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
